// File: rtl/bcd_conv_ctrl.sv
// bcd_conv_ctrl: sequential double-dabble binary-to-BCD converter (WIDTH shift cycles per operand).
// Optional 7-segment output enabled by macro BCD_SEG7_EN.
module bcd_conv_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg_out
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [4*DIGITS-1:0] acc, adj;
  logic [WIDTH-1:0] sr;
  logic accept, last;
  // busy and done are registered from the state, so the IDLE cycle right after DONE still reads busy
  assign accept = state == IDLE && !busy && start;
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    next = state == IDLE  ? (accept ? SHIFT : IDLE) :
           state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    adj = acc;
    for (int d = 0; d < DIGITS; d++)
      adj[4*d+:4] = acc[4*d+:4] >= 4'd5 ? acc[4*d+:4] + 4'd3 : acc[4*d+:4];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      cnt     <= '0;
      acc     <= '0;
      sr      <= '0;
    end else begin
      state <= next;
      busy  <= state != IDLE;
      done  <= state == DONE;
      if (accept) begin
        sr  <= bin_in;
        acc <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        {acc, sr} <= {adj[4*DIGITS-2:0], sr, 1'b0};
        cnt       <= cnt + 1'b1;
      end
      if (state == DONE) bcd_out <= acc;
    end
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    always_ff @(posedge clk)
      if (rst_n && state == SHIFT) assert (acc[4*g+:4] <= 4'd9);
  end
`ifdef BCD_SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
  always_ff @(posedge clk) begin
    if (!rst_n) seg_out <= '1;
    else if (state == DONE)
      for (int d = 0; d < DIGITS; d++) seg_out[7*d+:7] <= seg7(acc[4*d+:4]);
  end
`endif
endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// tb_bcd_conv_ctrl: vector table plus corner sequences; a done-time scoreboard checks every result.
module tb_bcd_conv_ctrl;
  localparam int WIDTH = 8;
  localparam int DIGITS = 3;
  logic clk = 1'b0;
  logic rst_n, start;
  logic [WIDTH-1:0] bin_in;
  logic busy, done;
  logic [4*DIGITS-1:0] bcd_out;
`ifdef BCD_SEG7_EN
  logic [7*DIGITS-1:0] seg_out;
`endif
  bcd_conv_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out)
`ifdef BCD_SEG7_EN
    , .seg_out(seg_out)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [11:0] bcd; int due;} exp_t;
  typedef struct {logic [7:0] bin; logic [11:0] bcd;} vec_t;
  exp_t q[$];
  exp_t e_m;
  vec_t vt[12];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [11:0] last_bcd = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Scoreboard: each accepted conversion owes exactly one done at a fixed edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e_m = q.pop_front();
        chk("done_cycle", cyc, e_m.due);
        chk("bcd_result", bcd_out, e_m.bcd);
      end
    end else if (q.size() > 0 && cyc >= q[0].due) begin
      chk("missing_done", 0, 1);
      void'(q.pop_front());
    end
  end
  task automatic run_conv(input logic [7:0] b, input logic [11:0] x, input bit glitch);
    int nb;
    start = 1'b1;
    bin_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    bin_in = ~b;
    q.push_back('{x, cyc + WIDTH + 1});
    nb = 0;
    for (int i = 1; i <= WIDTH + 2; i++) begin
      if (glitch && i == 2) begin
        start = 1'b1;
        bin_in = 8'd200;
      end
      if (i == 6) start = 1'b0;
      @(posedge clk); #1;
      if (busy) nb++;
      if (i <= WIDTH) chk("bcd_hold", bcd_out, last_bcd);
    end
    chk("busy_cycles", nb, WIDTH + 1);
    last_bcd = x;
  endtask
  initial begin
    vt[0]  = '{8'd0,   12'h000};
    vt[1]  = '{8'd255, 12'h255};
    vt[2]  = '{8'd99,  12'h099};
    vt[3]  = '{8'd100, 12'h100};
    vt[4]  = '{8'd1,   12'h001};
    vt[5]  = '{8'd9,   12'h009};
    vt[6]  = '{8'd10,  12'h010};
    vt[7]  = '{8'd128, 12'h128};
    vt[8]  = '{8'd199, 12'h199};
    vt[9]  = '{8'd59,  12'h059};
    vt[10] = '{8'd250, 12'h250};
    vt[11] = '{8'd77,  12'h077};
    rst_n = 1'b0;
    start = 1'b0;
    bin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 0);
`ifdef BCD_SEG7_EN
    chk("rst_seg", seg_out, 21'h1FFFFF);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (vt[i]) run_conv(vt[i].bin, vt[i].bcd, 1'b0);
    run_conv(8'd37, 12'h037, 1'b1);
    start = 1'b1;
    bin_in = 8'd42;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k % 11 == 0) q.push_back('{12'h042, cyc + WIDTH + 1});
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("b2b_bcd", bcd_out, 12'h042);
    start = 1'b1;
    bin_in = 8'd123;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd_out, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_idle_busy", busy, 0);
    last_bcd = '0;
    rst_n = 1'b0;
    start = 1'b1;
    bin_in = 8'd55;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_busy", busy, 0);
    run_conv(8'd80, 12'h080, 1'b0);
`ifdef BCD_SEG7_EN
    chk("seg_80", seg_out, {7'b1000000, 7'b0000000, 7'b1000000});
`endif
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
